croc_obi_rule_demux: RTL and testbench

- Parametrised single-manager to N-subordinate OBI demultiplexer; routing comes from an array of address-map rules.
- Each rule is {idx, start_addr, end_addr}, matching when start_addr <= addr < end_addr.
- Contains an internal error subordinate for unmapped addresses and tracks outstanding transactions so responses stay in order.
- Successor to the fixed crossbar/peripheral decode in croc_domain; usable for peripheral and user-domain fan-out.

---
 rtl/croc_obi_rule_demux.sv | 147 ++++++++++++++
 tb/tb_croc_obi_rule_demux.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/croc_obi_rule_demux.sv
// Rule-based OBI demultiplexer: one manager fanned out to NumSbr subordinates by an address map,
// with an internal error subordinate for unmapped addresses and in-order response tracking.
package croc_pkg;
   typedef struct packed {
      logic [31:0] idx;
      logic [31:0] start_addr;
      logic [31:0] end_addr;
   } addr_map_rule_t;
endpackage

module croc_obi_rule_demux #(
   parameter int unsigned NumSbr   = 2,
   parameter int unsigned NumRules = 2,
   parameter croc_pkg::addr_map_rule_t [NumRules-1:0] AddrMap = '{
      '{idx: 32'd1, start_addr: 32'h1000_0000, end_addr: 32'h1000_1000},
      '{idx: 32'd0, start_addr: 32'h0000_0000, end_addr: 32'h1000_0000}
   },
   parameter int unsigned MaxTrans = 2,
   parameter int unsigned IdWidth  = 1,
   parameter logic [31:0] ErrData  = 32'hBADCAB1E
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        mgr_req_i,
   input  logic [31:0]                 mgr_addr_i,
   input  logic                        mgr_we_i,
   input  logic [3:0]                  mgr_be_i,
   input  logic [31:0]                 mgr_wdata_i,
   input  logic [IdWidth-1:0]          mgr_aid_i,
   output logic                        mgr_gnt_o,
   output logic                        mgr_rvalid_o,
   output logic [31:0]                 mgr_rdata_o,
   output logic [IdWidth-1:0]          mgr_rid_o,
   output logic                        mgr_err_o,
   output logic [NumSbr-1:0]           sbr_req_o,
   output logic [31:0]                 sbr_addr_o,
   output logic                        sbr_we_o,
   output logic [3:0]                  sbr_be_o,
   output logic [31:0]                 sbr_wdata_o,
   output logic [IdWidth-1:0]          sbr_aid_o,
   input  logic [NumSbr-1:0]           sbr_gnt_i,
   input  logic [NumSbr-1:0]           sbr_rvalid_i,
   input  logic [NumSbr*32-1:0]        sbr_rdata_i,
   input  logic [NumSbr*IdWidth-1:0]   sbr_rid_i,
   input  logic [NumSbr-1:0]           sbr_err_i
);

   localparam int unsigned SelWidth = $clog2(NumSbr + 1);
   localparam int unsigned CntWidth = $clog2(MaxTrans + 1);
   localparam logic [SelWidth-1:0] ErrSel = SelWidth'(NumSbr);
   localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTrans);

   logic [SelWidth-1:0] dec, sel_q;
   logic [CntWidth-1:0] cnt_q;
   logic                err_rvalid_q;
   logic [IdWidth-1:0]  err_rid_q;
   logic                allow, tgt_gnt, accept, dec_is_err, sel_is_err;
   logic                rsp_valid, sel_rvalid, sel_err;
   logic [31:0]         sel_rdata;
   logic [IdWidth-1:0]  sel_rid;

   // Walk rules from the highest index down so the lowest matching rule has the final say.
   always_comb begin
      dec = ErrSel;
      for (int k = int'(NumRules) - 1; k >= 0; k--) begin
         if ((mgr_addr_i >= AddrMap[k].start_addr) && (mgr_addr_i < AddrMap[k].end_addr)) begin
            dec = AddrMap[k].idx[SelWidth-1:0];
         end
      end
   end

   assign dec_is_err = (dec == ErrSel);
   assign sel_is_err = (sel_q == ErrSel);

   // Only one target may be outstanding at a time, so responses return in issue order.
   assign allow = (cnt_q == '0) | ((dec == sel_q) & (cnt_q < CntMax));

   always_comb begin
      tgt_gnt   = 1'b0;
      sbr_req_o = '0;
      for (int i = 0; i < int'(NumSbr); i++) begin
         if (dec == SelWidth'(i)) begin
            tgt_gnt      = sbr_gnt_i[i];
            sbr_req_o[i] = mgr_req_i & allow;
         end
      end
   end

   assign mgr_gnt_o = allow & mgr_req_i & (dec_is_err | tgt_gnt);
   assign accept    = mgr_req_i & mgr_gnt_o;

   assign sbr_addr_o  = mgr_addr_i;
   assign sbr_we_o    = mgr_we_i;
   assign sbr_be_o    = mgr_be_i;
   assign sbr_wdata_o = mgr_wdata_i;
   assign sbr_aid_o   = mgr_aid_i;

   always_comb begin
      sel_rvalid = 1'b0;
      sel_rdata  = '0;
      sel_rid    = '0;
      sel_err    = 1'b0;
      for (int i = 0; i < int'(NumSbr); i++) begin
         if (sel_q == SelWidth'(i)) begin
            sel_rvalid = sbr_rvalid_i[i];
            sel_rdata  = sbr_rdata_i[32*i +: 32];
            sel_rid    = sbr_rid_i[IdWidth*i +: IdWidth];
            sel_err    = sbr_err_i[i];
         end
      end
   end

   // Response fields are held at zero whenever no response is being presented.
   assign rsp_valid    = sel_is_err ? err_rvalid_q : (sel_rvalid & (cnt_q != '0));
   assign mgr_rvalid_o = rsp_valid;
   assign mgr_err_o    = rsp_valid & (sel_is_err | sel_err);
   assign mgr_rdata_o  = !rsp_valid ? '0 : (sel_is_err ? ErrData : sel_rdata);
   assign mgr_rid_o    = !rsp_valid ? '0 : (sel_is_err ? err_rid_q : sel_rid);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q        <= '0;
         sel_q        <= '0;
         err_rvalid_q <= 1'b0;
         err_rid_q    <= '0;
      end else begin
         if (accept && !rsp_valid) begin
            cnt_q <= cnt_q + CntWidth'(1);
         end else if (!accept && rsp_valid) begin
            cnt_q <= cnt_q - CntWidth'(1);
         end
         if (accept) begin
            sel_q <= dec;
         end
         err_rvalid_q <= accept & dec_is_err;
         if (accept && dec_is_err) begin
            err_rid_q <= mgr_aid_i;
         end
      end
   end

   for (genvar g = 0; g < int'(NumSbr); g++) begin : gen_rvalid_chk
      assert property (@(posedge clk_i) disable iff (!rst_ni)
         (sbr_rvalid_i[g] && (cnt_q != '0)) |-> (sel_q == SelWidth'(g)));
   end

endmodule

// File: tb/tb_croc_obi_rule_demux.sv
// Scoreboard bench for croc_obi_rule_demux: directed requests push expected responses,
// a negedge monitor pops and compares whenever the manager sees rvalid.
module tb_croc_obi_rule_demux;

   typedef struct packed {
      logic [31:0] rdata;
      logic [0:0]  rid;
      logic        err;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rstN;

   logic        req, we;
   logic [31:0] addr, wdata;
   logic [3:0]  be;
   logic [0:0]  aid;
   logic        gnt, rvalid, err;
   logic [31:0] rdata;
   logic [0:0]  rid;
   logic [1:0]  sbrReq;
   logic [31:0] sbrAddr, sbrWdata;
   logic        sbrWe;
   logic [3:0]  sbrBe;
   logic [0:0]  sbrAid;
   logic [1:0]  sbrGnt, sbrRvalid, sbrRid, sbrErr;
   logic [63:0] sbrRdata;

   logic        ovlReq;
   logic [31:0] ovlAddr;
   logic        ovlGnt, ovlRvalid, ovlErr;
   logic [31:0] ovlRdata, ovlSbrAddr, ovlSbrWdata;
   logic [0:0]  ovlRid, ovlSbrAid;
   logic [1:0]  ovlSbrReq;
   logic        ovlSbrWe;
   logic [3:0]  ovlSbrBe;

   rsp_t expQ[$];
   rsp_t monExp;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   croc_obi_rule_demux dut (
      .clk_i(clk), .rst_ni(rstN),
      .mgr_req_i(req), .mgr_addr_i(addr), .mgr_we_i(we), .mgr_be_i(be),
      .mgr_wdata_i(wdata), .mgr_aid_i(aid),
      .mgr_gnt_o(gnt), .mgr_rvalid_o(rvalid), .mgr_rdata_o(rdata),
      .mgr_rid_o(rid), .mgr_err_o(err),
      .sbr_req_o(sbrReq), .sbr_addr_o(sbrAddr), .sbr_we_o(sbrWe), .sbr_be_o(sbrBe),
      .sbr_wdata_o(sbrWdata), .sbr_aid_o(sbrAid),
      .sbr_gnt_i(sbrGnt), .sbr_rvalid_i(sbrRvalid), .sbr_rdata_i(sbrRdata),
      .sbr_rid_i(sbrRid), .sbr_err_i(sbrErr)
   );

   // Second instance with overlapping rules: rule 0 covers rule 1 entirely, so rule 0 must win.
   croc_obi_rule_demux #(
      .AddrMap('{
         '{idx: 32'd1, start_addr: 32'h1000_0000, end_addr: 32'h1000_1000},
         '{idx: 32'd0, start_addr: 32'h0000_0000, end_addr: 32'h2000_0000}
      })
   ) dutOvl (
      .clk_i(clk), .rst_ni(rstN),
      .mgr_req_i(ovlReq), .mgr_addr_i(ovlAddr), .mgr_we_i(1'b0), .mgr_be_i(4'hF),
      .mgr_wdata_i(32'h0), .mgr_aid_i(1'b0),
      .mgr_gnt_o(ovlGnt), .mgr_rvalid_o(ovlRvalid), .mgr_rdata_o(ovlRdata),
      .mgr_rid_o(ovlRid), .mgr_err_o(ovlErr),
      .sbr_req_o(ovlSbrReq), .sbr_addr_o(ovlSbrAddr), .sbr_we_o(ovlSbrWe), .sbr_be_o(ovlSbrBe),
      .sbr_wdata_o(ovlSbrWdata), .sbr_aid_o(ovlSbrAid),
      .sbr_gnt_i(2'b00), .sbr_rvalid_i(2'b00), .sbr_rdata_i(64'h0),
      .sbr_rid_i(2'b00), .sbr_err_i(2'b00)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [31:0] a, input logic [0:0] id,
                                input logic w, input logic [31:0] d);
      req   = r;
      addr  = a;
      aid   = id;
      we    = w;
      wdata = d;
      be    = 4'hF;
   endtask

   task automatic driveResponse(input int port, input logic [31:0] d, input logic id, input logic e);
      sbrRvalid = '0;
      sbrRvalid[port] = 1'b1;
      sbrRdata[32*port +: 32] = d;
      sbrRid[port] = id;
      sbrErr[port] = e;
   endtask

   task automatic clearResponse();
      sbrRvalid = '0;
      sbrRdata  = '0;
      sbrRid    = '0;
      sbrErr    = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every response seen by the manager must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rstN && rvalid) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL rsp_unexpected: got rdata=0x%0h rid=%0d err=%0b, required no response",
                     rdata, rid, err);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("rsp_rdata", 64'(rdata), 64'(monExp.rdata));
            checkOutput("rsp_rid", 64'(rid), 64'(monExp.rid));
            checkOutput("rsp_err", 64'(err), 64'(monExp.err));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   logic [31:0] decAddr [5];
   logic [1:0]  decReq  [5];

   initial begin
      rstN = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      sbrGnt = 2'b11;
      clearResponse();
      ovlReq = 1'b0;
      ovlAddr = 32'h0;

      #3;
      checkOutput("rst_gnt", 64'(gnt), 64'd0);
      checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
      checkOutput("rst_err", 64'(err), 64'd0);
      checkOutput("rst_rdata", 64'(rdata), 64'd0);
      checkOutput("rst_rid", 64'(rid), 64'd0);
      checkOutput("rst_sbr_req", 64'(sbrReq), 64'd0);
      tick();
      tick();
      rstN = 1'b1;

      // Single read to sbr1 with one-cycle response
      applyStimulus(1'b1, 32'h1000_0004, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("t1_sbr_req", 64'(sbrReq), 64'h2);
      checkOutput("t1_gnt", 64'(gnt), 64'd1);
      expQ.push_back('{rdata: 32'h1234_5678, rid: 1'b1, err: 1'b0});
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      driveResponse(1, 32'h1234_5678, 1'b1, 1'b0);
      @(negedge clk);
      tick();
      clearResponse();
      @(negedge clk);
      checkOutput("t1_cnt", 64'(dut.cnt_q), 64'd0);
      tick();

      // Back-to-back unmapped reads answered by the error subordinate
      applyStimulus(1'b1, 32'h8000_0000, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("t2_gnt_a", 64'(gnt), 64'd1);
      checkOutput("t2_sbr_req_a", 64'(sbrReq), 64'd0);
      expQ.push_back('{rdata: 32'hBADC_AB1E, rid: 1'b1, err: 1'b1});
      tick();
      applyStimulus(1'b1, 32'h1000_1000, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("t2_gnt_b", 64'(gnt), 64'd1);
      checkOutput("t2_sbr_req_b", 64'(sbrReq), 64'd0);
      expQ.push_back('{rdata: 32'hBADC_AB1E, rid: 1'b0, err: 1'b1});
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("t2_rvalid_b", 64'(rvalid), 64'd1);
      tick();
      @(negedge clk);
      checkOutput("t2_rvalid_idle", 64'(rvalid), 64'd0);
      checkOutput("t2_cnt", 64'(dut.cnt_q), 64'd0);
      tick();

      // Decode boundaries with subordinates withholding grant
      sbrGnt = 2'b00;
      decAddr = '{32'h0000_0000, 32'h0FFF_FFFC, 32'h0FFF_FFFF, 32'h1000_0000, 32'h1000_0FFF};
      decReq  = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
      for (int v = 0; v < 5; v++) begin
         applyStimulus(1'b1, decAddr[v], 1'b0, 1'b0, 32'h0);
         @(negedge clk);
         checkOutput($sformatf("dec_req_%0h", decAddr[v]), 64'(sbrReq), 64'(decReq[v]));
         checkOutput($sformatf("dec_gnt_%0h", decAddr[v]), 64'(gnt), 64'd0);
         tick();
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      sbrGnt = 2'b11;
      tick();

      // Outstanding limit toward sbr0, with simultaneous accept and response
      applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b1, 32'hCAFE_0001);
      @(negedge clk);
      checkOutput("t3_gnt_a", 64'(gnt), 64'd1);
      checkOutput("t3_sbr_req_a", 64'(sbrReq), 64'h1);
      checkOutput("t3_sbr_addr", 64'(sbrAddr), 64'h100);
      checkOutput("t3_sbr_we", 64'(sbrWe), 64'd1);
      checkOutput("t3_sbr_wdata", 64'(sbrWdata), 64'hCAFE_0001);
      checkOutput("t3_sbr_be", 64'(sbrBe), 64'hF);
      expQ.push_back('{rdata: 32'hA0, rid: 1'b0, err: 1'b0});
      tick();
      @(negedge clk);
      checkOutput("t3_gnt_b", 64'(gnt), 64'd1);
      expQ.push_back('{rdata: 32'hA1, rid: 1'b0, err: 1'b0});
      tick();
      @(negedge clk);
      checkOutput("t3_gnt_full", 64'(gnt), 64'd0);
      checkOutput("t3_sbr_req_full", 64'(sbrReq), 64'd0);
      checkOutput("t3_cnt_full", 64'(dut.cnt_q), 64'd2);
      tick();
      driveResponse(0, 32'hA0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t3_gnt_rsp", 64'(gnt), 64'd0);
      checkOutput("t3_sbr_req_rsp", 64'(sbrReq), 64'd0);
      tick();
      driveResponse(0, 32'hA1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t3_gnt_c", 64'(gnt), 64'd1);
      checkOutput("t3_sbr_req_c", 64'(sbrReq), 64'h1);
      checkOutput("t3_cnt_c", 64'(dut.cnt_q), 64'd1);
      expQ.push_back('{rdata: 32'hA2, rid: 1'b0, err: 1'b0});
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      driveResponse(0, 32'hA2, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t3_cnt_both", 64'(dut.cnt_q), 64'd1);
      tick();
      clearResponse();
      @(negedge clk);
      checkOutput("t3_cnt_end", 64'(dut.cnt_q), 64'd0);
      tick();

      // Switching target stalls until the previous target has drained
      applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("t4_gnt_a", 64'(gnt), 64'd1);
      expQ.push_back('{rdata: 32'hB0, rid: 1'b0, err: 1'b0});
      tick();
      applyStimulus(1'b1, 32'h1000_0000, 1'b1, 1'b0, 32'h0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checkOutput("t4_gnt_stall", 64'(gnt), 64'd0);
         checkOutput("t4_sbr_req_stall", 64'(sbrReq), 64'd0);
         tick();
      end
      driveResponse(0, 32'hB0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t4_gnt_rsp", 64'(gnt), 64'd0);
      checkOutput("t4_sbr_req_rsp", 64'(sbrReq), 64'd0);
      tick();
      clearResponse();
      @(negedge clk);
      checkOutput("t4_gnt_b", 64'(gnt), 64'd1);
      checkOutput("t4_sbr_req_b", 64'(sbrReq), 64'h2);
      expQ.push_back('{rdata: 32'hB1, rid: 1'b1, err: 1'b1});
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      driveResponse(1, 32'hB1, 1'b1, 1'b1);
      @(negedge clk);
      tick();
      clearResponse();
      @(negedge clk);
      checkOutput("t4_cnt_end", 64'(dut.cnt_q), 64'd0);
      tick();

      // Overlapping map: lowest rule index wins
      ovlReq = 1'b1;
      ovlAddr = 32'h1000_0000;
      @(negedge clk);
      checkOutput("t5_ovl_req_base", 64'(ovlSbrReq), 64'h1);
      tick();
      ovlAddr = 32'h1000_0FFC;
      @(negedge clk);
      checkOutput("t5_ovl_req_top", 64'(ovlSbrReq), 64'h1);
      tick();
      ovlReq = 1'b0;

      // Asynchronous reset with a transaction in flight
      applyStimulus(1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("t6_gnt", 64'(gnt), 64'd1);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("t6_cnt_before", 64'(dut.cnt_q), 64'd1);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("t6_rst_gnt", 64'(gnt), 64'd0);
      checkOutput("t6_rst_rvalid", 64'(rvalid), 64'd0);
      checkOutput("t6_rst_sbr_req", 64'(sbrReq), 64'd0);
      checkOutput("t6_rst_rdata", 64'(rdata), 64'd0);
      checkOutput("t6_rst_cnt", 64'(dut.cnt_q), 64'd0);
      tick();
      rstN = 1'b1;
      driveResponse(0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t6_late_rvalid", 64'(rvalid), 64'd0);
      tick();
      clearResponse();
      applyStimulus(1'b1, 32'h1000_0010, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("t6_gnt_new", 64'(gnt), 64'd1);
      checkOutput("t6_sbr_req_new", 64'(sbrReq), 64'h2);
      expQ.push_back('{rdata: 32'hC1, rid: 1'b1, err: 1'b0});
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      driveResponse(1, 32'hC1, 1'b1, 1'b0);
      @(negedge clk);
      tick();
      clearResponse();
      @(negedge clk);
      checkOutput("end_cnt", 64'(dut.cnt_q), 64'd0);
      checkOutput("end_queue_empty", 64'(expQ.size()), 64'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
